// File: rtl/subtractor_pipe_pkg.sv
// Shared Q-format helpers for the pipelined subtractor.
package subtractor_pipe_pkg;

    localparam int MAX_WIDTH = 64;

    localparam logic [MAX_WIDTH-1:0] ONE = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

    // Total data width of a Q(i,f) operand, sign bit included in i_width.
    function automatic int q_width(input int i_width, input int f_width);
        return i_width + f_width;
    endfunction

    // Most positive value of a w-bit two's-complement word, zero-extended.
    function automatic logic [MAX_WIDTH-1:0] q_max(input int w);
        return (ONE << (w - 1)) - ONE;
    endfunction

    // Most negative value of a w-bit two's-complement word, zero-extended.
    function automatic logic [MAX_WIDTH-1:0] q_min(input int w);
        return ONE << (w - 1);
    endfunction

endpackage

// File: rtl/subtractor_without_en.sv
// Combinational a - b with unsigned borrow and signed overflow flags.
module subtractor_without_en #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o,
    output logic         ovf_o
);

    logic [W:0] wide;

    // Subtract at W+1 bits; the extra bit is the unsigned borrow.
    always_comb begin
        wide     = {1'b0, a_i} - {1'b0, b_i};
        diff_o   = wide[W-1:0];
        borrow_o = wide[W];
        ovf_o    = (a_i[W-1] != b_i[W-1]) && (wide[W-1] != a_i[W-1]);
    end

endmodule

// File: rtl/subtractor_pipe.sv
// Two-stage valid/ready pipelined signed subtractor with optional saturation.
module subtractor_pipe
    import subtractor_pipe_pkg::*;
#(
    parameter  int I_WIDTH  = 8,
    parameter  int F_WIDTH  = 8,
    parameter  int SATURATE = 0,
    localparam int W        = q_width(I_WIDTH, F_WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [W-1:0] diff_o,
    output logic         borrow_o,
    output logic         ovf_o,
    output logic         valid_o,
    input  logic         ready_i
);

    localparam logic [MAX_WIDTH-1:0] MAX_FULL = q_max(W);
    localparam logic [MAX_WIDTH-1:0] MIN_FULL = q_min(W);
    localparam logic [W-1:0]         Q_MAX    = MAX_FULL[W-1:0];
    localparam logic [W-1:0]         Q_MIN    = MIN_FULL[W-1:0];

    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         s1_valid;

    logic         s1_adv;
    logic         s2_adv;

    logic [W-1:0] sub_diff;
    logic         sub_borrow;
    logic         sub_ovf;
    logic [W-1:0] out_diff;

    subtractor_without_en #(
        .W(W)
    ) u_sub (
        .a_i      (s1_a),
        .b_i      (s1_b),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow),
        .ovf_o    (sub_ovf)
    );

    // Handshake: each stage advances when it is empty or the stage after it moves.
    always_comb begin
        s2_adv  = !valid_o || ready_i;
        s1_adv  = !s1_valid || s2_adv;
        ready_o = s1_adv;
    end

    // Saturation clamps toward the sign of the minuend; flags stay unsaturated.
    always_comb begin
        out_diff = sub_diff;
        if (SATURATE != 0 && sub_ovf) begin
            out_diff = s1_a[W-1] ? Q_MIN : Q_MAX;
        end
    end

    // Stage-1 valid bit; in-flight operands are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= valid_i;
        end
    end

    // Stage-1 operand capture, only on an accepted input transfer.
    always_ff @(posedge clk) begin
        if (s1_adv && valid_i) begin
            s1_a <= a_i;
            s1_b <= b_i;
        end
    end

    // Stage-2 output registers; hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o  <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
            ovf_o    <= 1'b0;
        end else if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                diff_o   <= out_diff;
                borrow_o <= sub_borrow;
                ovf_o    <= sub_ovf;
            end
        end
    end

endmodule

// File: tb/tb_subtractor_pipe.sv
// Randomized and directed bench for subtractor_pipe (wrap and saturate builds).
module tb_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        valid_i;
    logic        ready_i;

    logic        ready_w, valid_w, borrow_w, ovf_w;
    logic [15:0] diff_w;
    logic        ready_s, valid_s, borrow_s, ovf_s;
    logic [15:0] diff_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subtractor_pipe #(
        .I_WIDTH (8),
        .F_WIDTH (8),
        .SATURATE(0)
    ) dut_wrap (
        .clk     (clk),
        .rst     (rst),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_i (valid_i),
        .ready_o (ready_w),
        .diff_o  (diff_w),
        .borrow_o(borrow_w),
        .ovf_o   (ovf_w),
        .valid_o (valid_w),
        .ready_i (ready_i)
    );

    subtractor_pipe #(
        .I_WIDTH (8),
        .F_WIDTH (8),
        .SATURATE(1)
    ) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_i (valid_i),
        .ready_o (ready_s),
        .diff_o  (diff_s),
        .borrow_o(borrow_s),
        .ovf_o   (ovf_s),
        .valid_o (valid_s),
        .ready_i (ready_i)
    );

    // Reference model: ordered list of accepted operand pairs, each tagged
    // with the edge count after which it may first be presented.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          ts;
    } item_t;

    item_t q[$];
    int    edges      = 0;
    bit    model_ok   = 1'b0;
    bit    just_reset = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Plain-integer reference: returns {borrow, ovf, diff}.
    function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input bit sat);
        int          d;
        logic        ovf;
        logic        brw;
        logic [15:0] r;
        d   = int'($signed(a)) - int'($signed(b));
        ovf = (d > 32767) || (d < -32768);
        brw = (a < b);
        r   = d[15:0];
        if (sat && ovf) r = (d > 0) ? 16'h7FFF : 16'h8000;
        return {brw, ovf, r};
    endfunction

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic ri, input logic r, output logic acc);
        logic        exp_valid;
        logic        exp_ready;
        logic [17:0] ew;
        logic [17:0] es;
        item_t       it;
        @(negedge clk);
        valid_i = v;
        a_i     = a;
        b_i     = b;
        ready_i = ri;
        rst     = r;
        #1;
        exp_valid = (q.size() > 0) && (q[0].ts <= edges);
        exp_ready = (q.size() < 2) || ri;
        if (model_ok) begin
            check("ready_wrap", 16'(ready_w), 16'(exp_ready));
            check("ready_sat",  16'(ready_s), 16'(exp_ready));
            check("valid_wrap", 16'(valid_w), 16'(exp_valid));
            check("valid_sat",  16'(valid_s), 16'(exp_valid));
            if (exp_valid) begin
                ew = ref_sub(q[0].a, q[0].b, 1'b0);
                es = ref_sub(q[0].a, q[0].b, 1'b1);
                check("diff_wrap",   diff_w,          ew[15:0]);
                check("borrow_wrap", 16'(borrow_w),   16'(ew[17]));
                check("ovf_wrap",    16'(ovf_w),      16'(ew[16]));
                check("diff_sat",    diff_s,          es[15:0]);
                check("borrow_sat",  16'(borrow_s),   16'(es[17]));
                check("ovf_sat",     16'(ovf_s),      16'(es[16]));
            end
            if (just_reset) begin
                check("rst_diff_wrap",   diff_w,        16'h0000);
                check("rst_borrow_wrap", 16'(borrow_w), 16'h0000);
                check("rst_ovf_wrap",    16'(ovf_w),    16'h0000);
                check("rst_diff_sat",    diff_s,        16'h0000);
                check("rst_borrow_sat",  16'(borrow_s), 16'h0000);
                check("rst_ovf_sat",     16'(ovf_s),    16'h0000);
            end
        end
        @(posedge clk);
        edges++;
        acc = 1'b0;
        if (r) begin
            q.delete();
            model_ok   = 1'b1;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (exp_valid && ri) void'(q.pop_front());
            if (v && exp_ready) begin
                it.a  = a;
                it.b  = b;
                it.ts = edges + 1;
                q.push_back(it);
                acc = 1'b1;
            end
        end
    endtask

    logic [15:0] va[8];
    logic [15:0] vb[8];

    initial begin
        logic acc;
        int   k;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = '0;
        b_i     = '0;

        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        step(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, acc);

        // Directed operand pairs, including the overflow corners.
        va[0] = 16'h0300; vb[0] = 16'h0100;
        va[1] = 16'h0100; vb[1] = 16'h0300;
        va[2] = 16'h8000; vb[2] = 16'h0001;
        va[3] = 16'h7FFF; vb[3] = 16'hFFFF;
        va[4] = 16'h0000; vb[4] = 16'h8000;
        va[5] = 16'hFFFF; vb[5] = 16'h7FFF;
        va[6] = 16'h8000; vb[6] = 16'h8000;
        va[7] = 16'h0000; vb[7] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, va[i], vb[i], 1'b1, 1'b0, acc);
            step(1'b0, $urandom, $urandom, 1'b1, 1'b0, acc);
        end
        for (int i = 0; i < 8; i++) step(1'b1, va[i], vb[i], 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, $urandom, $urandom, 1'b1, 1'b0, acc);

        // Back-pressure: four pairs with the consumer stalled for four cycles.
        k = 0;
        for (int c = 0; c < 40 && (k < 4 || q.size() > 0); c++) begin
            step(k < 4, 16'h0400 + 16'(k), 16'h0100, c >= 4, 1'b0, acc);
            if (acc) k++;
        end
        check("bp_accepted", 16'(k), 16'd4);
        check("bp_drained", 16'(q.size()), 16'd0);

        // Reset with both stages full.
        step(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0, acc);
        step(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0, acc);
        step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b0, acc);
        step(1'b1, 16'h4444, 16'h0004, 1'b0, 1'b1, acc);
        for (int i = 0; i < 4; i++) step(1'b0, $urandom, $urandom, 1'b1, 1'b0, acc);

        // Random traffic with random stalls and corner-biased operands.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
            if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001;
            step($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0, acc);
        end
        for (int i = 0; i < 6; i++) step(1'b0, $urandom, $urandom, 1'b1, 1'b0, acc);
        check("final_drained", 16'(q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
